core_boot_ctrl: RTL
===================

# core_boot_ctrl

Boot and run sequencer for the 5-stage RV32I core. It accepts 32-bit instruction words from a host over a valid/ready stream and writes them byte-by-byte, big-endian, into the core's byte-addressed instruction RAM. It holds the core in reset while loading, releases it, and lets it run for a programmed number of cycles before halting memory access. It sits between the host/test harness and the core's `clock`/`reset`/`mem_en` inputs and the instruction-memory write port, so loading no longer needs hierarchical RAM pokes.

## Interface
- `IMEM_BYTES`, 1024 — instruction RAM size in bytes; multiple of 4.
- `ADDR_W`, $clog2(IMEM_BYTES) — byte-address width.
- `HOLD_CYCLES`, 3 — cycles `core_reset` stays asserted after the last word is written; ≥1.
- `clock  in  1` — single clock; all logic is rising-edge.
- `reset  in  1` — synchronous, active-low; 0 at a rising edge resets the block.
- `start  in  1` — begin a load; sampled in IDLE, DONE, ERR.
- `host_valid  in  1` — host word valid.
- `host_ready  out  1` — block accepts a word.
- `host_data  in  32` — instruction word.
- `host_last  in  1` — qualifies the final word of the program.
- `run_limit  in  32` — core run length in cycles; sampled on leaving HOLD.
- `imem_we  out  1` — instruction RAM byte write enable.
- `imem_addr  out  ADDR_W` — byte address.
- `imem_wdata  out  8` — byte data.
- `core_reset  out  1` — active-high reset to the core.
- `core_mem_en  out  1` — memory enable to the core.
- `busy  out  1` — high in RECV, WRITE, HOLD, RUN.
- `done  out  1` — high in DONE.
- `error  out  1` — high in ERR.
- `word_count  out  ADDR_W-1` — words written in the current load.
- `cycle_count  out  32` — core cycles elapsed in RUN.

## Operation
- **States:** IDLE, RECV, WRITE, HOLD, RUN, DONE, ERR.
- **IDLE**
  - `start` → RECV.
  - On entry to RECV from IDLE, DONE or ERR: `word_count` and `cycle_count` clear.
- **RECV**
  - `host_ready`=1.
  - On `host_valid`&&`host_ready`:
    - latch `host_data` and `host_last`;
    - if `word_count` == IMEM_BYTES/4 → ERR, nothing written;
    - else → WRITE with byte index 0.
- **WRITE** (exactly 4 cycles)
  - `imem_we`=1, `imem_addr` = `word_count`*4 + k, for k = 0..3.
  - `imem_wdata` = word[31:24], [23:16], [15:8], [7:0] in that order.
  - After k=3: `word_count`++, then → HOLD if the latched last flag is set, else → RECV.
- **HOLD**
  - `core_reset`=1 for HOLD_CYCLES cycles (down-counter), then → RUN.
  - On leaving HOLD: latch `run_limit`. If it is 0, go straight to DONE.
- **RUN**
  - `core_reset`=0, `core_mem_en`=1, `cycle_count` increments each cycle.
  - When `cycle_count` == latched limit − 1 → DONE. The core therefore runs exactly `run_limit` cycles.
  - `cycle_count` saturates at 2^32−1.
- **DONE**
  - `core_mem_en`=0, `core_reset`=0 (core frozen, state inspectable), `done`=1.
  - `start` → RECV, a new load from address 0.
- **ERR**
  - `error`=1, `core_reset`=1, `host_ready`=0.
  - `start` → RECV.
- `core_reset`=1 in every state except RUN and DONE.
- `host_valid` outside RECV is ignored; no word is lost, because the host holds it until `host_ready`.
- `start` outside IDLE/DONE/ERR is ignored.

## Timing
- **Reset values** (`reset`=0 at a rising edge):
  - state IDLE;
  - `host_ready`, `imem_we`, `imem_addr`, `imem_wdata`, `core_mem_en`, `busy`, `done`, `error`, `word_count`, `cycle_count` all 0;
  - `core_reset` 1.
- Reset mid-operation (any state) takes effect on the next edge. A partially written word is abandoned and the core is held in reset.
- All outputs are registered.
- Handshake edge → first `imem_we` cycle: next cycle. Word throughput is 1 per 5 cycles (1 RECV + 4 WRITE).
- Last byte write → first cycle of RUN: HOLD_CYCLES + 1 cycles.
- `busy` drops in the same cycle `done` or `error` rises.
- Simultaneous `start` and `host_valid` in IDLE: only the state change occurs. The word is accepted next cycle in RECV.

## Test plan
- **Single-word load:** load 32'h00500093 with `host_last`=1 → bytes 00,50,00,93 at addresses 0..3 on 4 consecutive cycles; `core_reset` high 3 more cycles, then low; `word_count`=1.
- **Four-word program and run:** words 0, 00500093, 00500113, fe209ce3 (last), `run_limit`=80 → RAM bytes 0..15 match big-endian; `core_mem_en` high exactly 80 cycles; `done`=1; `cycle_count`=79.
- **Backpressure and idle:** `host_valid` toggles randomly; `host_ready` is low during WRITE → no duplicated or dropped words; the address sequence is contiguous.
- **Overflow:** `IMEM_BYTES`=16, send 5 words → first 4 are written, fifth raises `error`, no write to address 16; `start` restarts the load at address 0.
- **`run_limit`=0 and mid-RUN reset:** `run_limit`=0 → DONE directly after HOLD, `core_mem_en` never high. Separately, `reset`=0 during RUN → next cycle IDLE, `core_reset`=1, all counters 0.

Source files
------------

// File: rtl/core_boot_ctrl.sv
// Boot/run sequencer: streams host words big-endian into byte-wide instruction RAM,
// holds the core in reset while loading, then runs it for a programmed cycle count.
module core_boot_ctrl #(
    parameter int IMEM_BYTES  = 1024,
    parameter int ADDR_W      = $clog2(IMEM_BYTES),
    parameter int HOLD_CYCLES = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [31:0]       host_data,
    input  logic              host_last,
    input  logic [31:0]       run_limit,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [7:0]        imem_wdata,
    output logic              core_reset,
    output logic              core_mem_en,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-2:0] word_count,
    output logic [31:0]       cycle_count
);
    localparam int WC_W   = ADDR_W - 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [WC_W-1:0]   MAX_WORDS = WC_W'(IMEM_BYTES / 4);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RECV  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    logic [2:0]        r_state,       w_state_next;
    logic [31:0]       r_word,        w_word_next;
    logic              r_last,        w_last_next;
    logic [1:0]        r_byte_idx,    w_byte_next;
    logic [HOLD_W-1:0] r_hold_cnt,    w_hold_next;
    logic [31:0]       r_limit,       w_limit_next;
    logic [WC_W-1:0]   r_word_count,  w_wc_next;
    logic [31:0]       r_cycle_count, w_cc_next;

    logic              r_host_ready, r_imem_we, r_core_reset, r_core_mem_en;
    logic              r_busy, r_done, r_error;
    logic [ADDR_W-1:0] r_imem_addr, w_addr_next;
    logic [7:0]        r_imem_wdata, w_wdata_next;

    always_comb begin
        w_state_next = r_state;
        w_word_next  = r_word;
        w_last_next  = r_last;
        w_byte_next  = r_byte_idx;
        w_hold_next  = r_hold_cnt;
        w_limit_next = r_limit;
        w_wc_next    = r_word_count;
        w_cc_next    = r_cycle_count;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    w_state_next = S_RECV;
                    w_wc_next    = '0;
                    w_cc_next    = '0;
                end
            end
            S_RECV: begin
                if (host_valid && r_host_ready) begin
                    w_word_next = host_data;
                    w_last_next = host_last;
                    if (r_word_count == MAX_WORDS) begin
                        w_state_next = S_ERR;
                    end else begin
                        w_state_next = S_WRITE;
                        w_byte_next  = 2'd0;
                    end
                end
            end
            S_WRITE: begin
                if (r_byte_idx == 2'd3) begin
                    w_wc_next    = r_word_count + WC_W'(1);
                    w_hold_next  = HOLD_INIT;
                    w_state_next = r_last ? S_HOLD : S_RECV;
                end else begin
                    w_byte_next = r_byte_idx + 2'd1;
                end
            end
            S_HOLD: begin
                if (r_hold_cnt == '0) begin
                    w_limit_next = run_limit;
                    w_state_next = (run_limit == 32'd0) ? S_DONE : S_RUN;
                end else begin
                    w_hold_next = r_hold_cnt - HOLD_W'(1);
                end
            end
            S_RUN: begin
                // Stop on the last counted cycle so the core sees exactly run_limit cycles.
                if (r_cycle_count == r_limit - 32'd1) begin
                    w_state_next = S_DONE;
                end else if (r_cycle_count != '1) begin
                    w_cc_next = r_cycle_count + 32'd1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with the state.
    always_comb begin
        w_addr_next  = '0;
        w_wdata_next = 8'd0;
        if (w_state_next == S_WRITE) begin
            w_addr_next = {w_wc_next[WC_W-2:0], w_byte_next};
            case (w_byte_next)
                2'd0:    w_wdata_next = w_word_next[31:24];
                2'd1:    w_wdata_next = w_word_next[23:16];
                2'd2:    w_wdata_next = w_word_next[15:8];
                default: w_wdata_next = w_word_next[7:0];
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_word        <= '0;
            r_last        <= 1'b0;
            r_byte_idx    <= '0;
            r_hold_cnt    <= '0;
            r_limit       <= '0;
            r_word_count  <= '0;
            r_cycle_count <= '0;
            r_host_ready  <= 1'b0;
            r_imem_we     <= 1'b0;
            r_imem_addr   <= '0;
            r_imem_wdata  <= 8'd0;
            r_core_reset  <= 1'b1;
            r_core_mem_en <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_word        <= w_word_next;
            r_last        <= w_last_next;
            r_byte_idx    <= w_byte_next;
            r_hold_cnt    <= w_hold_next;
            r_limit       <= w_limit_next;
            r_word_count  <= w_wc_next;
            r_cycle_count <= w_cc_next;
            r_host_ready  <= (w_state_next == S_RECV);
            r_imem_we     <= (w_state_next == S_WRITE);
            r_imem_addr   <= w_addr_next;
            r_imem_wdata  <= w_wdata_next;
            r_core_reset  <= !((w_state_next == S_RUN) || (w_state_next == S_DONE));
            r_core_mem_en <= (w_state_next == S_RUN);
            r_busy        <= (w_state_next == S_RECV) || (w_state_next == S_WRITE) ||
                             (w_state_next == S_HOLD) || (w_state_next == S_RUN);
            r_done        <= (w_state_next == S_DONE);
            r_error       <= (w_state_next == S_ERR);
        end
    end

    assign host_ready  = r_host_ready;
    assign imem_we     = r_imem_we;
    assign imem_addr   = r_imem_addr;
    assign imem_wdata  = r_imem_wdata;
    assign core_reset  = r_core_reset;
    assign core_mem_en = r_core_mem_en;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign word_count  = r_word_count;
    assign cycle_count = r_cycle_count;
endmodule
